bus_memory_target: RTL

Parametrised 8088 min-mode bus slave: memory or I/O target with internal address decode, configurable wait-state insertion via READY, and single-cycle-accurate read/write sequencing. Next generation of the bus memory/IO module; drop-in on the Intel8088Pins bus alongside other targets, one instance per decoded region.

---
 rtl/bus_memory_target_if.sv | 49 ++++
 rtl/bus_memory_target.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/bus_memory_target_if.sv
// ---------------------------------------------------------------------------
// bus_memory_target_if
//
// Purpose: 8088 minimum-mode bus bundle shared by one bus master and a memory/IO
//   target. DATA is the resolved bidirectional data bus. Each side drives it
//   through its own value/enable pair. The slave sees only the resolved DATA.
//
// Signals:
//   ALE       address latch enable (master -> slave)
//   IOM       1 = I/O cycle, 0 = memory cycle (master -> slave)
//   RD, WR    active-low read / write strobes (master -> slave)
//   ADDRESS   bus address (master -> slave)
//   DATA      resolved bidirectional data bus
//   mst_data  master drive value for DATA, enabled by mst_en
//   slv_data  slave drive value for DATA, enabled by slv_en
//   READY     0 = insert wait state (slave -> master)
//   HIT       registered: current cycle owned by the slave (slave -> master)
// ---------------------------------------------------------------------------
interface bus_memory_target_if #(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 8
);
  logic                  ALE;
  logic                  IOM;
  logic                  RD;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] ADDRESS;
  wire  [DATA_WIDTH-1:0] DATA;
  logic [DATA_WIDTH-1:0] mst_data;
  logic                  mst_en;
  logic [DATA_WIDTH-1:0] slv_data;
  logic                  slv_en;
  logic                  READY;
  logic                  HIT;

  // Two tristate drivers resolve onto the shared data bus.
  assign DATA = mst_en ? mst_data : {DATA_WIDTH{1'bz}};
  assign DATA = slv_en ? slv_data : {DATA_WIDTH{1'bz}};

  modport master (
    output ALE, IOM, RD, WR, ADDRESS, mst_data, mst_en,
    input  DATA, READY, HIT
  );

  modport slave (
    input  ALE, IOM, RD, WR, ADDRESS, DATA,
    output slv_data, slv_en, READY, HIT
  );
endinterface

// File: rtl/bus_memory_target.sv
// ---------------------------------------------------------------------------
// bus_memory_target
//
// Purpose: 8088 minimum-mode bus slave. It acts as a memory or I/O target for
//   one decoded region. It decodes the address internally, inserts a
//   configurable number of wait states through READY, and sequences each read
//   or write to the exact cycle.
//
// Ports:
//   CLK    bus clock
//   RESET  asynchronous, active-high reset
//   WP     write protect; exists only when BUSMEM_WRITE_PROTECT_EN is defined.
//          When WP=1 at the commit cycle, the write is discarded. The
//          handshake is unchanged.
//   bus    slave modport of bus_memory_target_if, carrying
//          ALE/IOM/RD/WR/ADDRESS/DATA/READY/HIT
//
// Optional feature macro: BUSMEM_WRITE_PROTECT_EN
// ---------------------------------------------------------------------------
module bus_memory_target #(
  parameter int                    ADDR_WIDTH     = 20,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 20'h00000,
  parameter bit                    IS_IO          = 1'b0,
  parameter int                    READ_WAIT      = 1,
  parameter int                    WRITE_WAIT     = 0,
  parameter string                 INIT_FILE      = "memory_init.mem"
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef BUSMEM_WRITE_PROTECT_EN
  input  logic                WP,
`endif
  bus_memory_target_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, RWAIT, RDRIVE, WWAIT, WCOMMIT, DONE
  } state_t;

  localparam logic [3:0] RD_WAIT_INIT = 4'(READ_WAIT);
  localparam logic [3:0] WR_WAIT_INIT = 4'(WRITE_WAIT);

  state_t                    state_q, state_d;
  logic [3:0]                wait_q, wait_d;
  logic [MEM_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic                      hit_q, hit_d;

  logic [DATA_WIDTH-1:0]     mem [2**MEM_ADDR_WIDTH];
  logic                      decode_hit;
  logic                      mem_we;
  logic                      wp_block;

  // Comparing the shifted address and base also covers MEM_ADDR_WIDTH == ADDR_WIDTH
  // (a single region spans the whole bus).
  assign decode_hit = bus.ALE && (bus.IOM == IS_IO) &&
                      ((bus.ADDRESS >> MEM_ADDR_WIDTH) == (BASE_ADDR >> MEM_ADDR_WIDTH));

`ifdef BUSMEM_WRITE_PROTECT_EN
  assign wp_block = WP;
`else
  assign wp_block = 1'b0;
`endif

  // State register. Storage is excluded so that reset never touches it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      wait_q   <= '0;
      offset_q <= '0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      offset_q <= offset_d;
      hit_q    <= hit_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    offset_d = offset_q;
    hit_d    = hit_q;
    unique case (state_q)
      IDLE: begin
        if (decode_hit) begin
          offset_d = bus.ADDRESS[MEM_ADDR_WIDTH-1:0];
          hit_d    = 1'b1;
          state_d  = CMD;
        end
      end
      CMD: begin
        if (!bus.RD && !bus.WR) begin
          // Both strobes low is illegal: finish the cycle with no drive and no write.
          state_d = DONE;
        end else if (!bus.RD) begin
          wait_d  = RD_WAIT_INIT;
          state_d = (RD_WAIT_INIT == 4'd0) ? RDRIVE : RWAIT;
        end else if (!bus.WR) begin
          wait_d  = WR_WAIT_INIT;
          state_d = (WR_WAIT_INIT == 4'd0) ? WCOMMIT : WWAIT;
        end
      end
      RWAIT: begin
        if (bus.RD) begin
          state_d = DONE;            // master abandoned the read
        end else if (wait_q <= 4'd1) begin
          wait_d  = 4'd0;
          state_d = RDRIVE;
        end else begin
          wait_d  = wait_q - 4'd1;
        end
      end
      WWAIT: begin
        if (bus.WR) begin
          state_d = DONE;            // master abandoned the write
        end else if (wait_q <= 4'd1) begin
          wait_d  = 4'd0;
          state_d = WCOMMIT;
        end else begin
          wait_d  = wait_q - 4'd1;
        end
      end
      RDRIVE: begin
        if (bus.RD) state_d = DONE;
      end
      WCOMMIT: begin
        state_d = DONE;
      end
      DONE: begin
        // Hold until both strobes are released, so a lingering WR cannot
        // re-trigger a write and our driver cannot overlap the next T1.
        if (bus.RD && bus.WR) begin
          hit_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hit_d   = 1'b0;
        wait_d  = '0;
      end
    endcase
  end

  // Outputs are decoded from state_q. An asynchronous reset therefore releases
  // READY and DATA without waiting for a clock edge.
  assign bus.READY    = !((state_q == RWAIT) || (state_q == WWAIT));
  assign bus.HIT      = hit_q;
  assign bus.slv_en   = (state_q == RDRIVE);
  assign bus.slv_data = mem[offset_q];

  // The commit strobe lasts exactly one cycle, because WCOMMIT always moves
  // on to DONE.
  assign mem_we = (state_q == WCOMMIT) && !wp_block;

  // Storage write port
  always_ff @(posedge CLK) begin
    if (mem_we) mem[offset_q] <= bus.DATA;
  end

endmodule
